spi_master_fifo: RTL and testbench
==================================

Name: spi_master_fifo

Overview:
- Parametrised SPI master; next generation of the fixed 8-bit single-slave SPI cores in lms_ctr.
- Adds configurable word width, runtime CPOL/CPHA/bit order, programmable SCLK divider, N slave selects, TX/RX FIFOs and SS hold across back-to-back words.
- Sits between a CPU/register-bank streaming port and external SPI peripherals (ADF PLL, DAC, LMS chips).

Parameters:
- DATA_W, 8, SPI word width in bits (4..32).
- NUM_SS, 1, number of active-low slave-select lines (1..16).
- DIV_W, 8, width of the cfg_div half-period divider input.
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2, ≥2).
- SS_DELAY, 2, SCLK half-periods of SS setup before the first edge and hold after the last edge (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_cpol  in  1  SCLK idle level.
- cfg_cpha  in  1  0 = sample on first edge; 1 = sample on second edge.
- cfg_lsb_first  in  1  1 = LSB shifted first.
- cfg_div  in  DIV_W  half-period = cfg_div+1 clk cycles.
- cfg_ss_sel  in  NUM_SS  one-hot or multi-hot slave enable.
- cfg_ss_hold  in  1  keep SS asserted between words while TX FIFO is non-empty.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_W  received word (show-ahead FIFO head).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop RX FIFO.
- rx_overrun  out  1  sticky: a received word was dropped.
- clr_overrun  in  1  clears rx_overrun.
- busy  out  1  FSM not IDLE or TX FIFO non-empty.
- SCLK  out  1  SPI clock.
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in.
- SS_n  out  NUM_SS  slave selects, active low.

Behaviour:
- Reset values: SS_n all ones; SCLK 0; MOSI 0; tx_ready 1; rx_valid 0; rx_overrun 0; busy 0; both FIFOs empty; FSM IDLE. Reset mid-transfer aborts at the next clk edge with no RX push. SS deasserts immediately.
- Configuration inputs (cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_div, cfg_ss_sel) are latched when a word is loaded. Changes mid-word have no effect.
- In IDLE, SCLK follows cfg_cpol, registered with 1-cycle lag.
- TX FIFO write: tx_valid & tx_ready. RX FIFO pop: rx_valid & rx_ready. Simultaneous push and pop are legal in both FIFOs, and occupancy is unchanged.
- Tick: a divider counter runs only outside IDLE and produces one tick every cfg_div+1 cycles. It restarts at each state entry.
- IDLE: when the TX FIFO is non-empty, pop it into the shift register and go to LEAD. SS_n falls 2 clk cycles after the accepting tx handshake when starting from an empty FIFO.
- LEAD: SS_n = ~latched ss_sel. Lasts SS_DELAY ticks, then go to SHIFT. With CPHA=0, MOSI presents the first bit from LEAD entry.
- SHIFT: 2*DATA_W ticks, and SCLK toggles on every tick.
  - CPHA=0: sample MISO on odd edges (1,3,…); shift MOSI on even edges, except the final edge.
  - CPHA=1: shift MOSI on odd edges; sample MISO on even edges.
  - After the last edge SCLK = cpol. Then go to TRAIL.
- TRAIL: SS_DELAY ticks. At exit, push the received word into the RX FIFO.
  - If the RX FIFO is full at that point, discard the word and set rx_overrun. A simultaneous pop in the same cycle makes room, so the push succeeds.
  - Next state: if cfg_ss_hold and the TX FIFO is non-empty, pop the next word and go to LEAD with SS kept low. Otherwise go to GAP.
- GAP: SS_n all ones for SS_DELAY ticks, then go to IDLE.
- Word time = (2*SS_DELAY + 2*DATA_W) ticks, plus SS_DELAY ticks of GAP when SS is released.
- rx_overrun: clr_overrun clears it. If clr_overrun and a new overrun occur in the same cycle, the set wins.
- Bit order: MSB first unless cfg_lsb_first. The received word uses the same order as the transmitted word.

Test Plan:
- DATA_W=8, cfg_div=4, mode 0, MSB first, tx 0xA5, MISO looped to MOSI:
  - SCLK 10-cycle period, 8 rising edges.
  - MOSI 1,0,1,0,0,1,0,1 stable at each rising edge.
  - rx_data=0xA5.
  - SS_n low for 2*2+16 = 20 ticks = 100 cycles.
- Modes 1, 2, 3 with slave model returning 0x3C and tx 0xC3: rx_data=0x3C in every mode; SCLK idles at cfg_cpol; sample/shift edges match the CPHA rules.
- cfg_ss_hold=1, 4 words pushed back-to-back: SS_n stays low across all 4 words; 4 rx words in order; busy falls after GAP. With cfg_ss_hold=0, SS_n pulses high for 2 ticks between words.
- RX FIFO (depth 4) never popped, 5 words sent: first 4 retained; 5th dropped; rx_overrun=1; clr_overrun clears it; tx_ready deasserts when the TX FIFO holds 4.
- DATA_W=16, NUM_SS=3, cfg_lsb_first=1, cfg_ss_sel=3'b010, tx 0x8001:
  - SS_n=3'b101 during the transfer.
  - MOSI 1 first and 1 last.
- Reset asserted in SHIFT:
  - Next cycle SS_n=all ones, FSM in IDLE, FIFOs empty, no rx_valid.
  - A new transfer then runs correctly.

Source files
------------

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX show-ahead FIFOs, runtime CPOL/CPHA/bit order, SCLK divider and N slave selects.
// state | meaning
// IDLE  | no word in flight; SCLK follows cfg_cpol
// LEAD  | SS asserted, SS_DELAY ticks of setup before the first SCLK edge
// SHIFT | 2*DATA_W SCLK edges, one per tick
// TRAIL | SS_DELAY ticks of hold after the last edge; RX push or overrun at exit
// GAP   | SS released for SS_DELAY ticks before returning to IDLE
module spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int NUM_SS     = 1,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SS_DELAY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_SS-1:0] cfg_ss_sel,
  input  logic              cfg_ss_hold,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  input  logic              clr_overrun,
  output logic              busy,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (2 * DATA_W > SS_DELAY) ? 2 * DATA_W : SS_DELAY;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;
  state_t state;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0]     tx_cnt, rx_cnt;
  logic              tx_push, tx_pop, tx_empty, rx_push, rx_pop, rx_full;
  logic [DATA_W-1:0] tx_head, tx_sh, rx_sh;
  logic [DIV_W-1:0]  div_q, div_cnt;
  logic [TW-1:0]     tcnt;
  logic              cpha_q, lsb_q;
  logic              tick, last_tick, trail_done, overrun_set, sample_edge, shift_edge;

  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign tx_ready    = (tx_cnt != CW'(FIFO_DEPTH));
  assign tx_push     = tx_valid & tx_ready;
  assign tx_empty    = (tx_cnt == '0);
  assign tx_head     = tx_mem[tx_rptr];
  assign rx_valid    = (rx_cnt != '0);
  assign rx_pop      = rx_valid & rx_ready;
  assign rx_full     = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_data     = rx_mem[rx_rptr];
  assign busy        = (state != S_IDLE) | ~tx_empty;

  assign tick        = (state != S_IDLE) && (div_cnt == '0);
  assign last_tick   = tick && (tcnt == '0);
  assign trail_done  = (state == S_TRAIL) && last_tick;
  // A pop in the same cycle frees a slot, so the push still lands.
  assign rx_push     = trail_done && (!rx_full || rx_pop);
  assign overrun_set = trail_done && rx_full && !rx_pop;
  assign tx_pop      = ((state == S_IDLE) && !tx_empty) || (trail_done && cfg_ss_hold && !tx_empty);

  // tcnt counts down to zero, so its LSB gives edge parity (odd edge <=> tcnt odd).
  assign sample_edge = tcnt[0] ^ cpha_q;
  assign shift_edge  = cpha_q ? tcnt[0] : (~tcnt[0] & (tcnt != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr] <= tx_data;
        tx_wptr         <= tx_wptr + 1'b1;
      end
      if (tx_pop) tx_rptr <= tx_rptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      if (rx_push) begin
        rx_mem[rx_wptr] <= rx_sh;
        rx_wptr         <= rx_wptr + 1'b1;
      end
      if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      SS_n       <= '1;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      div_cnt    <= '0;
      div_q      <= '0;
      tcnt       <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (overrun_set)      rx_overrun <= 1'b1;
      else if (clr_overrun) rx_overrun <= 1'b0;

      if (tx_pop) begin
        state   <= S_LEAD;
        cpha_q  <= cfg_cpha;
        lsb_q   <= cfg_lsb_first;
        div_q   <= cfg_div;
        div_cnt <= cfg_div;
        tcnt    <= TW'(SS_DELAY - 1);
        SS_n    <= ~cfg_ss_sel;
        SCLK    <= cfg_cpol;
        rx_sh   <= '0;
        // CPHA=0 needs the first bit on MOSI before the first edge.
        if (!cfg_cpha) begin
          MOSI  <= head_bit(tx_head, cfg_lsb_first);
          tx_sh <= shift_word(tx_head, cfg_lsb_first);
        end else begin
          tx_sh <= tx_head;
        end
      end else if (state == S_IDLE) begin
        SCLK <= cfg_cpol;
      end else if (!tick) begin
        div_cnt <= div_cnt - 1'b1;
      end else begin
        div_cnt <= div_q;
        tcnt    <= tcnt - 1'b1;
        case (state)
          S_LEAD: if (tcnt == '0) begin
            state <= S_SHIFT;
            tcnt  <= TW'(2 * DATA_W - 1);
          end
          S_SHIFT: begin
            SCLK <= ~SCLK;
            if (sample_edge)
              rx_sh <= lsb_q ? {MISO, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], MISO};
            if (shift_edge) begin
              MOSI  <= head_bit(tx_sh, lsb_q);
              tx_sh <= shift_word(tx_sh, lsb_q);
            end
            if (tcnt == '0) begin
              state <= S_TRAIL;
              tcnt  <= TW'(SS_DELAY - 1);
            end
          end
          S_TRAIL: if (tcnt == '0) begin
            state <= S_GAP;
            SS_n  <= '1;
            tcnt  <= TW'(SS_DELAY - 1);
          end
          S_GAP: if (tcnt == '0) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: an 8-bit single-slave instance with a mode-aware slave model
// and a 16-bit three-slave instance for LSB-first and slave-select checks.
module tb_spi_master_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // 8-bit instance
  logic       cpol = 1'b0, cpha = 1'b0, lsb = 1'b0, ss_sel = 1'b1, ss_hold = 1'b0;
  logic [7:0] div = 8'd4;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, rx_ready = 1'b0, clr_overrun = 1'b0;
  logic       tx_ready, rx_valid, rx_overrun, busy, sclk, mosi, miso;
  logic [7:0] rx_data;
  logic [0:0] ss_n;
  logic       loopback = 1'b1, slave_miso = 1'b0;
  assign miso = loopback ? mosi : slave_miso;

  spi_master_fifo #(.DATA_W(8), .NUM_SS(1), .DIV_W(8), .FIFO_DEPTH(4), .SS_DELAY(2)) dut8 (
    .clk(clk), .reset(reset), .cfg_cpol(cpol), .cfg_cpha(cpha), .cfg_lsb_first(lsb),
    .cfg_div(div), .cfg_ss_sel(ss_sel), .cfg_ss_hold(ss_hold), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .clr_overrun(clr_overrun), .busy(busy),
    .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SS_n(ss_n));

  // 16-bit, 3-slave instance (mode 0, MISO looped back)
  logic        c16_lsb = 1'b1;
  logic [2:0]  c16_sel = 3'b010;
  logic [15:0] tx16_data = 16'h0000;
  logic        tx16_valid = 1'b0, rx16_ready = 1'b0;
  logic        tx16_ready, rx16_valid, rx16_overrun, busy16, sclk16, mosi16;
  logic [15:0] rx16_data;
  logic [2:0]  ss16_n;

  spi_master_fifo #(.DATA_W(16), .NUM_SS(3), .DIV_W(8), .FIFO_DEPTH(4), .SS_DELAY(2)) dut16 (
    .clk(clk), .reset(reset), .cfg_cpol(1'b0), .cfg_cpha(1'b0), .cfg_lsb_first(c16_lsb),
    .cfg_div(8'd1), .cfg_ss_sel(c16_sel), .cfg_ss_hold(1'b0), .tx_data(tx16_data),
    .tx_valid(tx16_valid), .tx_ready(tx16_ready), .rx_data(rx16_data), .rx_valid(rx16_valid),
    .rx_ready(rx16_ready), .rx_overrun(rx16_overrun), .clr_overrun(1'b0), .busy(busy16),
    .SCLK(sclk16), .MOSI(mosi16), .MISO(mosi16), .SS_n(ss16_n));

  // Slave model and bus monitor for the 8-bit instance; slave_rx records MOSI at the slave's sample edges.
  logic [7:0] slave_word = 8'h3C;
  logic [7:0] slave_rx = 8'h00;
  int         sidx = 0, n_rise = 0, n_ss_rise = 0;
  logic       ss_prev = 1'b1, sclk_prev = 1'b0, lead = 1'b0;
  time        t_ss_fall = 0, t_ss_rise = 0, t_rise1 = 0, t_rise2 = 0, ss_gap = 0;

  always @(ss_n or sclk) begin
    if (ss_n[0] !== ss_prev) begin
      if (ss_n[0] == 1'b0) begin
        t_ss_fall = $time;
        ss_gap    = $time - t_ss_rise;
        slave_rx  = 8'h00;
        n_rise    = 0;
        sidx      = 7;
        if (!cpha) begin
          slave_miso = slave_word[sidx];
          sidx--;
        end
      end else begin
        t_ss_rise = $time;
        n_ss_rise++;
      end
    end
    if (sclk !== sclk_prev && ss_n[0] == 1'b0) begin
      if (sclk) begin
        n_rise++;
        if (n_rise == 1) t_rise1 = $time;
        if (n_rise == 2) t_rise2 = $time;
      end
      lead = (sclk != cpol);
      if (lead == !cpha) begin
        slave_rx = {slave_rx[6:0], mosi};
      end else if (sidx >= 0) begin
        slave_miso = slave_word[sidx];
        sidx--;
      end
    end
    ss_prev   = ss_n[0];
    sclk_prev = sclk;
  end

  logic [15:0] cap16 = 16'h0000;
  logic [2:0]  ss16_seen = 3'b111;
  always @(posedge sclk16) begin
    if (ss16_n != 3'b111) begin
      cap16     = {cap16[14:0], mosi16};
      ss16_seen = ss16_n;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push8(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop8(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(rx_valid), 1);
    chk(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle8(input string tag);
    int i;
    i = 0;
    while (busy && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic run16(input string tag, input logic [15:0] d, input logic [15:0] exp_cap);
    int i;
    @(negedge clk);
    tx16_valid = 1'b1;
    tx16_data  = d;
    @(negedge clk);
    tx16_valid = 1'b0;
    i = 0;
    while (busy16 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_idle"}, 32'(busy16), 0);
    chk({tag, "_rx"}, 32'(rx16_data), 32'(d));
    chk({tag, "_mosi"}, 32'(cap16), 32'(exp_cap));
    chk({tag, "_ss_n"}, 32'(ss16_seen), 32'h5);
    chk({tag, "_ss_idle"}, 32'(ss16_n), 32'h7);
    rx16_ready = 1'b1;
    @(negedge clk);
    rx16_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] hw [4];
    int r0;
    hw = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (3) @(negedge clk);
    chk("rst_ss_n", 32'(ss_n), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_overrun", 32'(rx_overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ss16_n", 32'(ss16_n), 7);
    chk("rst_tx16_ready", 32'(tx16_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    // Mode 0, div 4, loopback: SS_n falls two cycles after the accepting handshake.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("t1_ss_before", 32'(ss_n), 1);
    @(negedge clk);
    chk("t1_ss_fall", 32'(ss_n), 0);
    wait_idle8("t1_idle");
    chk("t1_rises", 32'(n_rise), 8);
    chk("t1_sclk_period", 32'(t_rise2 - t_rise1), 100);
    chk("t1_ss_low_time", 32'(t_ss_rise - t_ss_fall), 1000);
    chk("t1_mosi_at_rise", 32'(slave_rx), 'hA5);
    chk("t1_sclk_idle", 32'(sclk), 0);
    pop8("t1_rx", 8'hA5);

    // Modes 1..3 against the slave model returning 0x3C.
    loopback   = 1'b0;
    slave_word = 8'h3C;
    for (int m = 1; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      @(negedge clk);
      chk($sformatf("m%0d_sclk_idle", m), 32'(sclk), 32'(cpol));
      push8(8'hC3);
      wait_idle8($sformatf("m%0d_idle", m));
      chk($sformatf("m%0d_slave_rx", m), 32'(slave_rx), 'hC3);
      chk($sformatf("m%0d_rises", m), 32'(n_rise), 8);
      chk($sformatf("m%0d_sclk_after", m), 32'(sclk), 32'(cpol));
      pop8($sformatf("m%0d_rx", m), 8'h3C);
    end
    cpol     = 1'b0;
    cpha     = 1'b0;
    loopback = 1'b1;

    // SS hold across four back-to-back words.
    div     = 8'd1;
    ss_hold = 1'b1;
    r0      = n_ss_rise;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1;
      tx_data  = hw[i];
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle8("hold_idle");
    chk("hold_ss_rises", n_ss_rise - r0, 1);
    for (int i = 0; i < 4; i++) pop8($sformatf("hold_rx%0d", i), hw[i]);

    // Without hold SS_n goes high between words: 2 GAP ticks (4 cycles) plus the IDLE pop cycle.
    ss_hold = 1'b0;
    r0      = n_ss_rise;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h5C;
    @(negedge clk);
    tx_data  = 8'hE7;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle8("nohold_idle");
    chk("nohold_ss_rises", n_ss_rise - r0, 2);
    chk("nohold_ss_gap", 32'(ss_gap), 50);
    pop8("nohold_rx0", 8'h5C);
    pop8("nohold_rx1", 8'hE7);

    // RX never popped: five words, fifth dropped.
    div = 8'd0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(i + 1);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("ovr_tx_full", 32'(tx_ready), 0);
    wait_idle8("ovr_idle");
    chk("ovr_flag", 32'(rx_overrun), 1);
    for (int i = 0; i < 4; i++) pop8($sformatf("ovr_rx%0d", i), 8'(i + 1));
    chk("ovr_rx_empty", 32'(rx_valid), 0);
    chk("ovr_flag_sticky", 32'(rx_overrun), 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("ovr_cleared", 32'(rx_overrun), 0);

    // 16-bit LSB-first on slave 1.
    run16("w16_a", 16'h8001, 16'h8001);
    run16("w16_b", 16'h0003, 16'hC000);

    // Reset in the middle of SHIFT with a second word queued.
    div = 8'd4;
    push8(8'h96);
    push8(8'h77);
    repeat (40) @(negedge clk);
    chk("rmid_in_shift", 32'(n_rise > 0 && n_rise < 8), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_ss_n", 32'(ss_n), 1);
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_rx_valid", 32'(rx_valid), 0);
    chk("rmid_tx_ready", 32'(tx_ready), 1);
    chk("rmid_sclk", 32'(sclk), 0);
    reset = 1'b0;
    push8(8'h5A);
    wait_idle8("rpost_idle");
    pop8("rpost_rx", 8'h5A);
    chk("rpost_rx_empty", 32'(rx_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
